mipi_pwr_seq: RTL
=================

MIPI_PWR_SEQ -- requirements
Module: mipi_pwr_seq

Interface
REQ-001 The block SHALL have parameter T_MCLK_CYC, default 1000, cycles of MCLK running before PWDN_N release.
REQ-002 The block SHALL have parameter T_PWDN_CYC, default 5000, cycles from PWDN_N release to RESET_N release.
REQ-003 The block SHALL have parameter T_RDY_CYC, default 20000, cycles from RESET_N release to ready.
REQ-004 The block SHALL have parameter T_OFF_CYC, default 1000, cycles from RESET_N assertion to PWDN_N/MCLK removal.
REQ-005 The block SHALL have parameter CNT_W, default 24, dwell-counter width; every T_* SHALL be 1 to 2^CNT_W-1.
REQ-006 The block SHALL have port clk, input, 1, system clock.
REQ-007 The block SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-008 The block SHALL have port pwr_req_n, input, 1, level power request from the PIO power-down register bit, clk domain; 1 = camera on, 0 = power-down.
REQ-009 The block SHALL have port cam_pwdn_n, output, 1, sensor power-down pin, 0 = powered down.
REQ-010 The block SHALL have port cam_reset_n, output, 1, sensor reset pin, 0 = in reset.
REQ-011 The block SHALL have port mclk_en, output, 1, sensor master-clock gate enable.
REQ-012 The block SHALL have port ready, output, 1, sensor released and settled; downstream I2C config and MIPI RX may start.
REQ-013 The block SHALL have port busy, output, 1, high in any transitional state.
REQ-014 The block SHALL have port state_o, output, 3, current state encoding, for a status register.

Function
REQ-015 The FSM SHALL have states OFF=0, MCLK_ON=1, PWDN_REL=2, RST_REL=3, READY=4, SHUTDOWN=5; codes 6-7 SHALL go to SHUTDOWN.
REQ-016 OFF: cam_pwdn_n=0, cam_reset_n=0, mclk_en=0, ready=0; pwr_req_n=1 SHALL move the FSM to MCLK_ON next cycle.
REQ-017 MCLK_ON: mclk_en=1, others 0; after T_MCLK_CYC cycles in state, the FSM SHALL move to PWDN_REL.
REQ-018 PWDN_REL: mclk_en=1, cam_pwdn_n=1; after T_PWDN_CYC cycles, the FSM SHALL move to RST_REL.
REQ-019 RST_REL: mclk_en=1, cam_pwdn_n=1, cam_reset_n=1; after T_RDY_CYC cycles, the FSM SHALL move to READY.
REQ-020 READY: as RST_REL plus ready=1; the FSM SHALL hold while pwr_req_n=1.
REQ-021 pwr_req_n=0 in MCLK_ON, PWDN_REL, RST_REL or READY SHALL move the FSM to SHUTDOWN next cycle, abandoning the dwell.
REQ-022 SHUTDOWN: cam_reset_n=0, ready=0; cam_pwdn_n and mclk_en SHALL be held at their values from entry; after T_OFF_CYC cycles, the FSM SHALL move to OFF.
REQ-023 pwr_req_n changes during SHUTDOWN SHALL be ignored; a still-high request SHALL restart from OFF (OFF held exactly one cycle).
REQ-024 The dwell counter SHALL clear on every state entry; a transition SHALL fire when count == T-1, so dwell = exactly T cycles.
REQ-025 All outputs SHALL be registered, changing on the clock edge that enters the state.
REQ-026 busy SHALL be 1 in MCLK_ON, PWDN_REL, RST_REL and SHUTDOWN; state_o SHALL equal the state code.
REQ-027 cam_reset_n=1 SHALL never occur with cam_pwdn_n=0 or mclk_en=0.

Reset
REQ-028 Asserting reset_n SHALL immediately force state OFF, all outputs 0 and counter 0, including mid-sequence.
REQ-029 After reset_n release, the FSM SHALL sample pwr_req_n on the first clk edge.

Structure
REQ-030 Package mipi_pwr_pkg SHALL hold the state enum/encodings and default T_* constants.
REQ-031 Sub-module mipi_pwr_dwell_cnt SHALL implement the clear/compare counter (inputs clr, limit; output done).

Verification
REQ-032 Params 4/6/8/3, pwr_req_n raised at t0: mclk_en @t0+1, cam_pwdn_n @+5, cam_reset_n @+11, ready @+19, busy low @+19.
REQ-033 Same params, pwr_req_n dropped in READY: cam_reset_n/ready low next cycle, cam_pwdn_n/mclk_en low 3 cycles later, state_o=0.
REQ-034 pwr_req_n dropped 2 cycles into PWDN_REL: SHUTDOWN with cam_pwdn_n=1 held, cam_reset_n never 1, OFF after 3 cycles.
REQ-035 pwr_req_n pulsed 0 then back to 1 during SHUTDOWN: SHUTDOWN completes, one OFF cycle, sequence restarts with full dwells.
REQ-036 reset_n asserted mid-RST_REL asynchronously: all outputs 0 before next edge; random request toggling checks REQ-027 continuously.

Source files
------------

// File: rtl/mipi_pwr_pkg.sv
// Shared definitions for the camera sensor power sequencer: the state
// encoding, which is visible through the status register, the default dwell
// times and the bundle of registered sequencer outputs.
package mipi_pwr_pkg;

  localparam int unsigned STATE_W = 3;

  // Default dwell times, in clk cycles
  localparam int unsigned T_MCLK_CYC_DEF = 1000;
  localparam int unsigned T_PWDN_CYC_DEF = 5000;
  localparam int unsigned T_RDY_CYC_DEF  = 20000;
  localparam int unsigned T_OFF_CYC_DEF  = 1000;
  localparam int unsigned CNT_W_DEF      = 24;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF      = 3'd0,
    ST_MCLK_ON  = 3'd1,
    ST_PWDN_REL = 3'd2,
    ST_RST_REL  = 3'd3,
    ST_READY    = 3'd4,
    ST_SHUTDOWN = 3'd5
  } pwr_state_e;

  typedef struct packed {
    logic cam_pwdn_n;
    logic cam_reset_n;
    logic mclk_en;
    logic ready;
    logic busy;
  } pwr_out_t;

endpackage

// File: rtl/mipi_pwr_dwell_cnt.sv
// Dwell counter for the power sequencer.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   clr          : zero the count (asserted on every state entry)
//   limit        : dwell length in cycles for the current state (>= 1)
//   done         : count has reached limit-1, i.e. this is the last dwell cycle
module mipi_pwr_dwell_cnt
  import mipi_pwr_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // Stops at limit-1 so the counter sits still in states with no dwell
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (!done) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/mipi_pwr_seq.sv
// Camera sensor power-up / power-down sequencer.
// Brings up MCLK, then releases PWDN_N, then RESET_N, each after a fixed
// dwell, and flags ready once the sensor has settled. Dropping the request
// at any point runs an orderly shutdown: RESET_N first, then PWDN_N and MCLK
// after T_OFF_CYC.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   pwr_req_n    : level power request, 1 = camera on, 0 = power-down
//   cam_pwdn_n   : sensor power-down pin (0 = powered down)
//   cam_reset_n  : sensor reset pin (0 = in reset)
//   mclk_en      : sensor master-clock gate enable
//   ready        : sensor released and settled
//   busy         : sequencer is in a transitional state
//   state_o      : current state code for the status register
module mipi_pwr_seq
  import mipi_pwr_pkg::*;
#(
  parameter int unsigned T_MCLK_CYC = T_MCLK_CYC_DEF,
  parameter int unsigned T_PWDN_CYC = T_PWDN_CYC_DEF,
  parameter int unsigned T_RDY_CYC  = T_RDY_CYC_DEF,
  parameter int unsigned T_OFF_CYC  = T_OFF_CYC_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pwr_req_n,
  output logic               cam_pwdn_n,
  output logic               cam_reset_n,
  output logic               mclk_en,
  output logic               ready,
  output logic               busy,
  output logic [STATE_W-1:0] state_o
);

  pwr_state_e       state;
  pwr_state_e       state_nxt;
  pwr_out_t         out_q;
  pwr_out_t         out_nxt;
  logic [CNT_W-1:0] dwell_limit;
  logic             dwell_clr;
  logic             dwell_done;

  mipi_pwr_dwell_cnt #(
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (dwell_clr),
    .limit   (dwell_limit),
    .done    (dwell_done)
  );

  // State and output registers; outputs are decoded from the next state so
  // they change on the same edge that enters the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_OFF;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      out_q <= out_nxt;
    end
  end

  // Next-state, dwell selection and next-output decode
  always_comb begin
    state_nxt   = state;
    dwell_limit = CNT_W'(1);
    out_nxt     = '0;

    case (state)
      ST_OFF: begin
        if (pwr_req_n) state_nxt = ST_MCLK_ON;
      end
      ST_MCLK_ON: begin
        dwell_limit = CNT_W'(T_MCLK_CYC);
        if (!pwr_req_n)      state_nxt = ST_SHUTDOWN;
        else if (dwell_done) state_nxt = ST_PWDN_REL;
      end
      ST_PWDN_REL: begin
        dwell_limit = CNT_W'(T_PWDN_CYC);
        if (!pwr_req_n)      state_nxt = ST_SHUTDOWN;
        else if (dwell_done) state_nxt = ST_RST_REL;
      end
      ST_RST_REL: begin
        dwell_limit = CNT_W'(T_RDY_CYC);
        if (!pwr_req_n)      state_nxt = ST_SHUTDOWN;
        else if (dwell_done) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (!pwr_req_n) state_nxt = ST_SHUTDOWN;
      end
      ST_SHUTDOWN: begin
        // Request is deliberately ignored until shutdown has completed
        dwell_limit = CNT_W'(T_OFF_CYC);
        if (dwell_done) state_nxt = ST_OFF;
      end
      default: begin
        state_nxt = ST_SHUTDOWN;
      end
    endcase

    dwell_clr = (state_nxt != state);

    case (state_nxt)
      ST_MCLK_ON: begin
        out_nxt.mclk_en = 1'b1;
        out_nxt.busy    = 1'b1;
      end
      ST_PWDN_REL: begin
        out_nxt.mclk_en    = 1'b1;
        out_nxt.cam_pwdn_n = 1'b1;
        out_nxt.busy       = 1'b1;
      end
      ST_RST_REL: begin
        out_nxt.mclk_en     = 1'b1;
        out_nxt.cam_pwdn_n  = 1'b1;
        out_nxt.cam_reset_n = 1'b1;
        out_nxt.busy        = 1'b1;
      end
      ST_READY: begin
        out_nxt.mclk_en     = 1'b1;
        out_nxt.cam_pwdn_n  = 1'b1;
        out_nxt.cam_reset_n = 1'b1;
        out_nxt.ready       = 1'b1;
      end
      ST_SHUTDOWN: begin
        // Keep PWDN_N and MCLK as they were on entry; reset drops at once
        out_nxt.mclk_en    = out_q.mclk_en;
        out_nxt.cam_pwdn_n = out_q.cam_pwdn_n;
        out_nxt.busy       = 1'b1;
      end
      default: begin
        out_nxt = '0;
      end
    endcase
  end

  assign cam_pwdn_n  = out_q.cam_pwdn_n;
  assign cam_reset_n = out_q.cam_reset_n;
  assign mclk_en     = out_q.mclk_en;
  assign ready       = out_q.ready;
  assign busy        = out_q.busy;
  assign state_o     = STATE_W'(state);

endmodule
